// File: rtl/bht_table_pkg.sv
// Shared types for the branch history table: 2-bit counter
// encodings and the saturating counter step.
package bht_table_pkg;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_ctr_e;

    localparam bht_ctr_e BHT_ALLOC_CTR = BHT_WT;

    function automatic bht_ctr_e ctr_next(bht_ctr_e c, logic taken);
        bht_ctr_e n;
        n = c;
        unique case (c)
            BHT_SNT: n = taken ? BHT_WNT : BHT_SNT;
            BHT_WNT: n = taken ? BHT_WT  : BHT_SNT;
            BHT_WT:  n = taken ? BHT_ST  : BHT_WNT;
            BHT_ST:  n = taken ? BHT_ST  : BHT_WT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bht_if.sv
// Lookup (IF) and update (EX) bundle between the pipeline and
// the branch history table.
interface bht_if #(
    parameter int PcWidth = 32
);
    logic [PcWidth-1:0] lookup_pc;
    logic               lookup_hit;
    logic               lookup_taken;
    logic [PcWidth-1:0] lookup_target;
    logic               update_en;
    logic [PcWidth-1:0] update_pc;
    logic               update_taken;
    logic [PcWidth-1:0] update_target;

    modport master (
        output lookup_pc, update_en, update_pc,
        output update_taken, update_target,
        input  lookup_hit, lookup_taken, lookup_target
    );

    modport slave (
        input  lookup_pc, update_en, update_pc,
        input  update_taken, update_target,
        output lookup_hit, lookup_taken, lookup_target
    );
endinterface

// File: rtl/bht_table_lru.sv
// Age-based LRU tracker over one-hot items; lru_item flags the
// entry that has gone longest without a touch.
module bht_table_lru #(
    parameter int NItem = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             touch_en,
    input  logic [NItem-1:0] touch_item,
    output logic [NItem-1:0] lru_item
);
    localparam int AgeW = (NItem > 1) ? $clog2(NItem) : 1;
    localparam logic [AgeW-1:0] Oldest = AgeW'(NItem - 1);

    logic [AgeW-1:0] age [NItem];
    logic [AgeW-1:0] t_age;

    always_comb begin
        t_age = '0;
        for (int i = 0; i < NItem; i++) begin
            if (touch_item[i]) t_age = t_age | age[i];
        end
    end

    // ages stay a permutation: younger-than-touched entries shift up by one
    for (genvar g = 0; g < NItem; g++) begin : g_age
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                age[g] <= AgeW'(NItem - 1 - g);
            end else if (touch_en) begin
                if (touch_item[g]) begin
                    age[g] <= '0;
                end else if (age[g] < t_age) begin
                    age[g] <= age[g] + AgeW'(1);
                end
            end
        end
        assign lru_item[g] = (age[g] == Oldest);
    end
endmodule

// File: rtl/bht_table.sv
// Fully associative branch history table: combinational lookup,
// resolved-branch update, LRU replacement once the table is full.
module bht_table
    import bht_table_pkg::*;
#(
    parameter int NItem   = 8,
    parameter int PcWidth = 32
) (
    input logic  clk,
    input logic  rst,
    bht_if.slave bus
);
    localparam int TagW = PcWidth - 2;

    logic               valid  [NItem];
    logic [TagW-1:0]    tag    [NItem];
    logic [PcWidth-1:0] target [NItem];
    bht_ctr_e           ctr    [NItem];

    logic [NItem-1:0] lk_hit, up_hit, inval, free_oh, victim_oh;
    logic [NItem-1:0] touch_item, lru_item, wr_hit, wr_alloc;
    logic             touch_en, up_any;

    always_comb begin
        for (int i = 0; i < NItem; i++) begin
            lk_hit[i] = valid[i] && (tag[i] == bus.lookup_pc[PcWidth-1:2]);
            up_hit[i] = valid[i] && (tag[i] == bus.update_pc[PcWidth-1:2]);
            inval[i]  = ~valid[i];
        end
    end

    // isolate the lowest set bit of the invalid mask
    assign free_oh    = inval & (~inval + NItem'(1));
    assign victim_oh  = (|inval) ? free_oh : lru_item;
    assign up_any     = |up_hit;
    assign touch_en   = bus.update_en && (up_any || bus.update_taken);
    assign touch_item = !touch_en ? '0 : (up_any ? up_hit : victim_oh);
    assign wr_hit     = {NItem{touch_en}} & up_hit;
    assign wr_alloc   = {NItem{touch_en && !up_any}} & victim_oh;

    assign bus.lookup_hit = |lk_hit;

    always_comb begin
        bus.lookup_taken  = 1'b0;
        bus.lookup_target = '0;
        for (int i = 0; i < NItem; i++) begin
            if (lk_hit[i]) begin
                bus.lookup_taken  = bus.lookup_taken | ctr[i][1];
                bus.lookup_target = bus.lookup_target | target[i];
            end
        end
    end

    for (genvar g = 0; g < NItem; g++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid[g]  <= 1'b0;
                tag[g]    <= '0;
                target[g] <= '0;
                ctr[g]    <= BHT_SNT;
            end else if (wr_alloc[g]) begin
                valid[g]  <= 1'b1;
                tag[g]    <= bus.update_pc[PcWidth-1:2];
                target[g] <= bus.update_target;
                ctr[g]    <= BHT_ALLOC_CTR;
            end else if (wr_hit[g]) begin
                ctr[g] <= ctr_next(ctr[g], bus.update_taken);
                if (bus.update_taken) target[g] <= bus.update_target;
            end
        end
    end

    bht_table_lru #(
        .NItem(NItem)
    ) u_lru (
        .clk       (clk),
        .rst_n     (~rst),
        .touch_en  (touch_en),
        .touch_item(touch_item),
        .lru_item  (lru_item)
    );
endmodule

// File: tb/tb_bht_table.sv
// Directed bench for bht_table: a table-level model with a recency
// list is compared every cycle, plus literal spot checks.
module tb_bht_table;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bht_if #(.PcWidth(32)) bus ();

    bht_table #(
        .NItem  (N),
        .PcWidth(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    bit          m_valid [N];
    int unsigned m_tag   [N];
    int unsigned m_tgt   [N];
    int          m_ctr   [N];
    int          lru_q[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        lru_q = {};
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 0;
            lru_q.push_back(i);
        end
    endtask

    function automatic int m_find(int unsigned pc);
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_tag[i] == (pc >> 2)) return i;
        return -1;
    endfunction

    task automatic m_pick(output bit en, output int idx);
        int h;
        en  = 0;
        idx = -1;
        if (bus.update_en !== 1'b1) return;
        h = m_find(bus.update_pc);
        if (h >= 0) begin
            en  = 1;
            idx = h;
            return;
        end
        if (bus.update_taken !== 1'b1) return;
        en  = 1;
        idx = lru_q[0];
        for (int i = N - 1; i >= 0; i--)
            if (!m_valid[i]) idx = i;
    endtask

    task automatic m_update();
        bit en;
        int k;
        m_pick(en, k);
        if (!en) return;
        if (m_find(bus.update_pc) == k) begin
            if (bus.update_taken) begin
                m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
                m_tgt[k] = bus.update_target;
            end else begin
                m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
            end
        end else begin
            m_valid[k] = 1;
            m_tag[k]   = bus.update_pc >> 2;
            m_tgt[k]   = bus.update_target;
            m_ctr[k]   = 2;
        end
        for (int i = 0; i < lru_q.size(); i++)
            if (lru_q[i] == k) begin
                lru_q.delete(i);
                break;
            end
        lru_q.push_back(k);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_update();
    end

    always @(negedge clk) begin
        if (!rst) begin
            int h;
            bit en;
            int k;
            h = m_find(bus.lookup_pc);
            chk("lookup_hit", bus.lookup_hit, (h >= 0));
            chk("lookup_taken", bus.lookup_taken, (h >= 0) && m_ctr[h] >= 2);
            chk("lookup_target", bus.lookup_target, (h >= 0) ? m_tgt[h] : 0);
            m_pick(en, k);
            chk("touch_en", dut.touch_en, en);
            chk("touch_item", dut.touch_item, en ? (32'd1 << k) : 0);
            for (int i = 0; i < N; i++) begin
                chk("valid", dut.valid[i], m_valid[i]);
                if (m_valid[i]) chk("ctr", dut.ctr[i], m_ctr[i]);
            end
        end
    end

    function automatic logic [31:0] pc_of(int i);
        return 32'h1000 + 32'(i) * 32'h10;
    endfunction

    function automatic logic [31:0] tg_of(int i);
        return 32'h8000 + 32'(i) * 32'h4;
    endfunction

    task automatic cyc(logic [31:0] lpc, bit en, logic [31:0] upc,
                       bit tk, logic [31:0] tgt);
        @(posedge clk);
        #1;
        bus.lookup_pc     = lpc;
        bus.update_en     = en;
        bus.update_pc     = upc;
        bus.update_taken  = tk;
        bus.update_target = tgt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.update_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fill(int n);
        for (int i = 0; i < n; i++) cyc(32'h0, 1, pc_of(i), 1, tg_of(i));
    endtask

    initial begin
        bus.lookup_pc     = 32'h100;
        bus.update_en     = 1'b0;
        bus.update_pc     = '0;
        bus.update_taken  = 1'b0;
        bus.update_target = '0;
        @(negedge clk);
        chk("rst_hit", bus.lookup_hit, 0);
        chk("rst_target", bus.lookup_target, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // empty table
        cyc(32'h100, 0, 0, 0, 0);
        chk("empty_hit", bus.lookup_hit, 0);
        chk("empty_taken", bus.lookup_taken, 0);
        chk("empty_target", bus.lookup_target, 0);
        chk("idle_touch", dut.touch_en, 0);

        // first allocation
        cyc(32'h100, 1, 32'h100, 1, 32'h200);
        chk("alloc_touch", dut.touch_item, 32'h1);
        cyc(32'h100, 0, 0, 0, 0);
        chk("alloc_hit", bus.lookup_hit, 1);
        chk("alloc_taken", bus.lookup_taken, 1);
        chk("alloc_target", bus.lookup_target, 32'h200);
        chk("alloc_ctr", dut.ctr[0], 2);

        // counter walks down and saturates
        cyc(32'h100, 1, 32'h100, 0, 32'h0);
        chk("nt1_pre_taken", bus.lookup_taken, 1);
        cyc(32'h100, 1, 32'h100, 0, 32'h0);
        chk("nt1_taken", bus.lookup_taken, 0);
        cyc(32'h100, 1, 32'h100, 0, 32'h0);
        chk("nt2_ctr", dut.ctr[0], 0);
        cyc(32'h100, 0, 0, 0, 0);
        chk("nt3_ctr", dut.ctr[0], 0);
        chk("nt3_target", bus.lookup_target, 32'h200);
        cyc(32'h300, 1, 32'h300, 0, 32'h0);
        chk("miss_nt_touch", dut.touch_en, 0);
        cyc(32'h300, 0, 0, 0, 0);
        chk("miss_nt_hit", bus.lookup_hit, 0);
        chk("miss_nt_valid1", dut.valid[1], 0);

        // fill and evict the untouched first PC
        do_reset();
        fill(N + 1);
        cyc(pc_of(0), 0, 0, 0, 0);
        chk("evict_first", bus.lookup_hit, 0);
        cyc(pc_of(8), 0, 0, 0, 0);
        chk("ninth_hit", bus.lookup_hit, 1);
        chk("ninth_target", bus.lookup_target, tg_of(8));
        cyc(pc_of(1), 0, 0, 0, 0);
        chk("second_kept", bus.lookup_hit, 1);

        // touching the first PC shifts eviction to the second
        do_reset();
        fill(N);
        cyc(32'h0, 1, pc_of(0), 1, tg_of(0));
        chk("touch_hit_item", dut.touch_item, 32'h1);
        cyc(32'h0, 1, pc_of(8), 1, tg_of(8));
        chk("victim_item", dut.touch_item, 32'h2);
        cyc(pc_of(1), 0, 0, 0, 0);
        chk("evict_second", bus.lookup_hit, 0);
        cyc(pc_of(0), 0, 0, 0, 0);
        chk("first_kept", bus.lookup_hit, 1);

        // same-cycle lookup sees the old state
        cyc(pc_of(0), 1, pc_of(0), 1, 32'hABC0);
        chk("same_cyc_target", bus.lookup_target, tg_of(0));
        cyc(pc_of(0), 0, 0, 0, 0);
        chk("next_cyc_target", bus.lookup_target, 32'hABC0);

        // asynchronous reset in the middle of an update
        @(posedge clk);
        #1;
        bus.update_en     = 1'b1;
        bus.update_pc     = pc_of(2);
        bus.update_taken  = 1'b1;
        bus.update_target = 32'h1234;
        #2;
        rst = 1'b1;
        #1;
        chk("async_hit", bus.lookup_hit, 0);
        chk("async_taken", bus.lookup_taken, 0);
        chk("async_target", bus.lookup_target, 0);
        bus.update_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(pc_of(0), 0, 0, 0, 0);
        chk("post_rst_hit", bus.lookup_hit, 0);
        cyc(pc_of(2), 0, 0, 0, 0);
        chk("post_rst_hit2", bus.lookup_hit, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
